// File: rtl/ucode_pkg.sv
// rtl/ucode_pkg.sv - shared constants, state enum and control-word field map for the microcode sequencer
package ucode_pkg;

  // Default control word width and the two sequencing bits stored above it
  localparam int CTRL_W_DFLT = 20;
  localparam int END_BIT     = CTRL_W_DFLT;
  localparam int HLT_BIT     = CTRL_W_DFLT + 1;

  // Sequencer states
  typedef enum logic [1:0] {
    S_HALT = 2'd0,
    S_RUN  = 2'd1,
    S_STEP = 2'd2
  } seq_state_t;

  // Default field map of the 20-bit control word as seen by the datapath
  localparam int CW_PC_OUT   = 0;
  localparam int CW_PC_INC   = 1;
  localparam int CW_PC_LD    = 2;
  localparam int CW_MAR_LD   = 3;
  localparam int CW_MEM_RD   = 4;
  localparam int CW_MEM_WR   = 5;
  localparam int CW_IR_LD    = 6;
  localparam int CW_IR_OUT   = 7;
  localparam int CW_A_LD     = 8;
  localparam int CW_A_OUT    = 9;
  localparam int CW_B_LD     = 10;
  localparam int CW_ALU_OUT  = 11;
  localparam int CW_ALU_SUB  = 12;
  localparam int CW_ALU_AND  = 13;
  localparam int CW_ALU_OR   = 14;
  localparam int CW_FLAG_LD  = 15;
  localparam int CW_OUT_LD   = 16;
  localparam int CW_SP_INC   = 17;
  localparam int CW_SP_DEC   = 18;
  localparam int CW_BUS_HOLD = 19;

endpackage

// File: rtl/ucode_sequencer_if.sv
// rtl/ucode_sequencer_if.sv - control, microcode-load and datapath-drive signals of the sequencer
interface ucode_sequencer_if #(
  parameter int OPCODE_W = 4,
  parameter int CTRL_W   = 20,
  parameter int MAX_T    = 6
);
  localparam int T_W    = $clog2(MAX_T);
  localparam int ADDR_W = OPCODE_W + T_W;

  // host / instruction register side
  logic                start;
  logic                step_mode;
  logic                step_req;
  logic [OPCODE_W-1:0] opcode_in;
  logic                ucode_we;
  logic [ADDR_W-1:0]   ucode_addr;
  logic [CTRL_W+1:0]   ucode_wdata;

  // datapath / status side
  logic [CTRL_W-1:0]   ctrl_word;
  logic [T_W-1:0]      t_state;
  logic [OPCODE_W-1:0] opcode_q;
  logic                instr_done;
  logic                halted;
  logic                ucode_err;

  modport master (
    output start, step_mode, step_req, opcode_in, ucode_we, ucode_addr, ucode_wdata,
    input  ctrl_word, t_state, opcode_q, instr_done, halted, ucode_err
  );

  modport slave (
    input  start, step_mode, step_req, opcode_in, ucode_we, ucode_addr, ucode_wdata,
    output ctrl_word, t_state, opcode_q, instr_done, halted, ucode_err
  );

endinterface

// File: rtl/ucode_store.sv
// rtl/ucode_store.sv - microcode RAM, synchronous write port and asynchronous read port
module ucode_store #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 22
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  // Contents are deliberately not reset; software loads them before start
  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ucode_sequencer.sv
// rtl/ucode_sequencer.sv - microcoded T-state sequencer driving the datapath control word
module ucode_sequencer
  import ucode_pkg::*;
#(
  parameter int OPCODE_W = 4,
  parameter int CTRL_W   = CTRL_W_DFLT,
  parameter int MAX_T    = 6,
  parameter int FETCH_T  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  ucode_sequencer_if.slave bus
);

  localparam int T_W     = $clog2(MAX_T);
  localparam int ADDR_W  = OPCODE_W + T_W;
  localparam int WORD_W  = CTRL_W + 2;
  localparam int HLT_IDX = CTRL_W + 1;
  localparam int END_IDX = CTRL_W;

  localparam logic [T_W-1:0] T_LAST       = T_W'(MAX_T - 1);
  localparam logic [T_W-1:0] T_FETCH      = T_W'(FETCH_T);
  localparam logic [T_W-1:0] T_FETCH_LAST = T_W'(FETCH_T - 1);

  seq_state_t          state_q, state_d;
  logic [T_W-1:0]      t_q, t_d;
  logic [OPCODE_W-1:0] op_q, op_d;
  logic [OPCODE_W-1:0] row;
  logic [ADDR_W-1:0]   raddr;
  logic [WORD_W-1:0]   word;
  logic                store_we;
  logic [CTRL_W-1:0]   ctrl_d;
  logic                done_d;
  logic                err_d;

  // Fetch T-states share row 0; execute T-states use the latched opcode
  assign row   = (t_q < T_FETCH) ? '0 : op_q;
  assign raddr = {row, t_q};

  ucode_store #(
    .ADDR_W (ADDR_W),
    .DATA_W (WORD_W)
  ) u_store (
    .clk   (clk),
    .we    (store_we),
    .waddr (bus.ucode_addr),
    .wdata (bus.ucode_wdata),
    .raddr (raddr),
    .rdata (word)
  );

  // State, T-state counter and latched opcode registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_HALT;
      t_q     <= '0;
      op_q    <= '0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      op_q    <= op_d;
    end
  end

  // Next state, counter advance, store write gating and per-cycle outputs
  always_comb begin
    state_d  = state_q;
    t_d      = t_q;
    op_d     = op_q;
    store_we = 1'b0;
    ctrl_d   = '0;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      S_HALT: begin
        // step_req has no meaning here; only start leaves HALT
        store_we = bus.ucode_we;
        if (bus.start) begin
          state_d = S_RUN;
          t_d     = '0;
        end
      end
      S_STEP: begin
        store_we = bus.ucode_we;
        if (bus.step_req || bus.start) begin
          state_d = S_RUN;
          t_d     = '0;
        end
      end
      S_RUN: begin
        ctrl_d = word[CTRL_W-1:0];
        // The store is live while running, so writes are refused and flagged
        err_d  = bus.ucode_we;
        if (word[HLT_IDX]) begin
          state_d = S_HALT;
          t_d     = '0;
        end else if (word[END_IDX] || (t_q == T_LAST)) begin
          // Wrap is forced at the last T-state even without an END bit
          done_d = 1'b1;
          t_d    = '0;
          if (bus.step_mode) begin
            state_d = S_STEP;
          end
        end else begin
          t_d = t_q + T_W'(1);
          if (t_q == T_FETCH_LAST) begin
            op_d = bus.opcode_in;
          end
        end
      end
      default: begin
        state_d = S_HALT;
        t_d     = '0;
      end
    endcase
  end

  assign bus.ctrl_word  = ctrl_d;
  assign bus.t_state    = t_q;
  assign bus.opcode_q   = op_q;
  assign bus.instr_done = done_d;
  assign bus.halted     = (state_q != S_RUN);
  assign bus.ucode_err  = err_d;

endmodule

// File: tb/tb_ucode_sequencer.sv
// tb/tb_ucode_sequencer.sv - directed, table-driven self-checking bench for ucode_sequencer
module tb_ucode_sequencer;
  import ucode_pkg::*;

  localparam int OPCODE_W = 4;
  localparam int CTRL_W   = 20;
  localparam int MAX_T    = 6;
  localparam int FETCH_T  = 2;
  localparam int NTBL     = 20;

  typedef struct {
    logic        st;
    logic        sm;
    logic        sr;
    logic [3:0]  op;
    logic        we;
    logic [6:0]  a;
    logic [21:0] d;
    logic [19:0] e_ctrl;
    logic [2:0]  e_t;
    logic        e_done;
    logic        e_halt;
    logic        e_err;
    logic [3:0]  e_opq;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  vec_t tbl [NTBL];
  vec_t v;

  always #5 clk = ~clk;

  ucode_sequencer_if #(.OPCODE_W(OPCODE_W), .CTRL_W(CTRL_W), .MAX_T(MAX_T)) bus ();

  ucode_sequencer #(
    .OPCODE_W (OPCODE_W),
    .CTRL_W   (CTRL_W),
    .MAX_T    (MAX_T),
    .FETCH_T  (FETCH_T)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic [6:0] ua(input int op, input int t);
    logic [3:0] o;
    logic [2:0] tt;
    o  = 4'(op);
    tt = 3'(t);
    return {o, tt};
  endfunction

  function automatic logic [21:0] uw(input logic h, input logic e, input logic [19:0] c);
    logic [21:0] w;
    w          = '0;
    w[HLT_BIT] = h;
    w[END_BIT] = e;
    w[19:0]    = c;
    return w;
  endfunction

  function automatic vec_t mk(input logic st, input logic sm, input logic sr, input logic [3:0] op,
                              input logic [19:0] c, input logic [2:0] t, input logic dn,
                              input logic hl, input logic er, input logic [3:0] oq);
    vec_t r;
    r.st = st; r.sm = sm; r.sr = sr; r.op = op;
    r.we = 1'b0; r.a = '0; r.d = '0;
    r.e_ctrl = c; r.e_t = t; r.e_done = dn; r.e_halt = hl; r.e_err = er; r.e_opq = oq;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic check_outs(input string nm, input logic [19:0] c, input logic [2:0] t,
                            input logic dn, input logic hl, input logic er, input logic [3:0] oq);
    chk({nm, ".ctrl"},   bus.ctrl_word,  c);
    chk({nm, ".t"},      bus.t_state,    t);
    chk({nm, ".done"},   bus.instr_done, dn);
    chk({nm, ".halted"}, bus.halted,     hl);
    chk({nm, ".err"},    bus.ucode_err,  er);
    chk({nm, ".opq"},    bus.opcode_q,   oq);
  endtask

  // One clock: drive at posedge+1, check at posedge+2, leave at next posedge+1
  task automatic cyc(input vec_t x, input string nm);
    bus.start       = x.st;
    bus.step_mode   = x.sm;
    bus.step_req    = x.sr;
    bus.opcode_in   = x.op;
    bus.ucode_we    = x.we;
    bus.ucode_addr  = x.a;
    bus.ucode_wdata = x.d;
    #1;
    check_outs(nm, x.e_ctrl, x.e_t, x.e_done, x.e_halt, x.e_err, x.e_opq);
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [6:0] a, input logic [21:0] d);
    bus.ucode_we    = 1'b1;
    bus.ucode_addr  = a;
    bus.ucode_wdata = d;
    @(posedge clk);
    #1;
    bus.ucode_we    = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bus.start = 0; bus.step_mode = 0; bus.step_req = 0; bus.opcode_in = 0;
    bus.ucode_we = 0; bus.ucode_addr = 0; bus.ucode_wdata = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_outs("reset", 20'h0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    rst_n = 1'b1;

    // Load: filler everywhere, then the program rows
    for (int a = 0; a < 128; a++) load(7'(a), uw(1'b0, 1'b0, 20'h80000 | 20'(a)));
    load(ua(0, 0), uw(0, 0, 20'h00001));
    load(ua(0, 1), uw(0, 0, 20'h00002));
    load(ua(5, 2), uw(0, 1, 20'h00010));
    for (int t = 2; t < 6; t++) load(ua(3, t), uw(0, 0, 20'h00300 | 20'(t)));
    load(ua(7, 2), uw(1, 0, 20'h00070));
    load(ua(9, 2), uw(0, 1, 20'h00090));

    // Row5 END instruction, row3 full-length wrap, row7 halt, restart
    tbl[0]  = mk(1, 0, 0, 5, 20'h0,     0, 0, 1, 0, 0);
    tbl[1]  = mk(0, 0, 0, 5, 20'h1,     0, 0, 0, 0, 0);
    tbl[2]  = mk(0, 0, 0, 5, 20'h2,     1, 0, 0, 0, 0);
    tbl[3]  = mk(0, 0, 0, 5, 20'h10,    2, 1, 0, 0, 5);
    tbl[4]  = mk(0, 0, 0, 3, 20'h1,     0, 0, 0, 0, 5);
    tbl[5]  = mk(0, 0, 0, 3, 20'h2,     1, 0, 0, 0, 5);
    tbl[6]  = mk(0, 0, 0, 3, 20'h302,   2, 0, 0, 0, 3);
    tbl[7]  = mk(0, 0, 0, 3, 20'h303,   3, 0, 0, 0, 3);
    tbl[8]  = mk(0, 0, 0, 3, 20'h304,   4, 0, 0, 0, 3);
    tbl[9]  = mk(0, 0, 0, 3, 20'h305,   5, 1, 0, 0, 3);
    tbl[10] = mk(0, 0, 0, 7, 20'h1,     0, 0, 0, 0, 3);
    tbl[11] = mk(0, 0, 0, 7, 20'h2,     1, 0, 0, 0, 3);
    tbl[12] = mk(0, 0, 0, 7, 20'h70,    2, 0, 0, 0, 7);
    tbl[13] = mk(1, 0, 0, 5, 20'h0,     0, 0, 1, 0, 7);
    tbl[14] = mk(0, 0, 0, 5, 20'h1,     0, 0, 0, 0, 7);
    tbl[15] = mk(0, 0, 0, 5, 20'h2,     1, 0, 0, 0, 7);
    tbl[16] = mk(0, 0, 0, 5, 20'h10,    2, 1, 0, 0, 5);
    tbl[17] = mk(0, 0, 0, 3, 20'h1,     0, 0, 0, 0, 5);
    tbl[18] = mk(0, 0, 0, 3, 20'h2,     1, 0, 0, 0, 5);
    tbl[19] = mk(0, 0, 0, 3, 20'h302,   2, 0, 0, 0, 3);
    for (int i = 0; i < NTBL; i++) cyc(tbl[i], $sformatf("tbl%0d", i));

    // Asynchronous reset while running at T3
    bus.start = 0; bus.opcode_in = 3;
    #1;
    check_outs("pre_rst", 20'h303, 3'd3, 1'b0, 1'b0, 1'b0, 4'd3);
    rst_n = 1'b0;
    #1;
    check_outs("mid_rst", 20'h0, 3'd0, 1'b0, 1'b1, 1'b0, 4'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) cyc(mk(0, 0, 0, 3, 20'h0, 0, 0, 1, 0, 0), $sformatf("post_rst%0d", i));
    cyc(mk(0, 0, 1, 3, 20'h0, 0, 0, 1, 0, 0), "halt_sreq");
    cyc(mk(0, 0, 0, 3, 20'h0, 0, 0, 1, 0, 0), "halt_sreq_ign");

    // Single-step: pause after each instruction until step_req
    cyc(mk(1, 1, 0, 9, 20'h0,  0, 0, 1, 0, 0), "st_start");
    cyc(mk(0, 1, 0, 9, 20'h1,  0, 0, 0, 0, 0), "st_t0");
    cyc(mk(0, 1, 0, 9, 20'h2,  1, 0, 0, 0, 0), "st_t1");
    cyc(mk(0, 1, 0, 9, 20'h90, 2, 1, 0, 0, 9), "st_t2");
    for (int i = 0; i < 10; i++) cyc(mk(0, 1, 0, 5, 20'h0, 0, 0, 1, 0, 9), $sformatf("st_wait%0d", i));
    for (int i = 0; i < 2; i++) cyc(mk(0, 0, 0, 5, 20'h0, 0, 0, 1, 0, 9), $sformatf("st_clr%0d", i));
    cyc(mk(0, 1, 1, 5, 20'h0,  0, 0, 1, 0, 9), "st_req");
    cyc(mk(0, 1, 0, 5, 20'h1,  0, 0, 0, 0, 9), "st2_t0");
    cyc(mk(0, 1, 0, 5, 20'h2,  1, 0, 0, 0, 9), "st2_t1");
    cyc(mk(0, 1, 0, 5, 20'h10, 2, 1, 0, 0, 5), "st2_t2");
    for (int i = 0; i < 3; i++) cyc(mk(0, 1, 0, 7, 20'h0, 0, 0, 1, 0, 5), $sformatf("st2_wait%0d", i));
    cyc(mk(1, 0, 0, 7, 20'h0,  0, 0, 1, 0, 5), "st_start_rel");

    // Write during RUN is refused and flagged
    v = mk(0, 0, 0, 7, 20'h1, 0, 0, 0, 1, 5);
    v.we = 1'b1; v.a = ua(5, 2); v.d = uw(0, 1, 20'h00055);
    cyc(v, "run_wr");
    cyc(mk(0, 0, 0, 7, 20'h2,  1, 0, 0, 0, 5), "run_wr_t1");
    cyc(mk(0, 0, 0, 7, 20'h70, 2, 0, 0, 0, 7), "run_wr_hlt");
    cyc(mk(1, 0, 0, 5, 20'h0,  0, 0, 1, 0, 7), "rb_start");
    cyc(mk(0, 0, 0, 5, 20'h1,  0, 0, 0, 0, 7), "rb_t0");
    cyc(mk(0, 0, 0, 5, 20'h2,  1, 0, 0, 0, 7), "rb_t1");
    cyc(mk(0, 0, 0, 5, 20'h10, 2, 1, 0, 0, 5), "rb_t2");
    cyc(mk(0, 0, 0, 7, 20'h1,  0, 0, 0, 0, 5), "h2_t0");
    cyc(mk(0, 0, 0, 7, 20'h2,  1, 0, 0, 0, 5), "h2_t1");
    cyc(mk(0, 0, 0, 7, 20'h70, 2, 0, 0, 0, 7), "h2_t2");

    // Write in HALT together with start: first fetch sees the new word
    v = mk(1, 0, 0, 5, 20'h0, 0, 0, 1, 0, 7);
    v.we = 1'b1; v.a = ua(0, 0); v.d = uw(0, 0, 20'h00abc);
    cyc(v, "halt_wr");
    cyc(mk(0, 0, 0, 5, 20'habc, 0, 0, 0, 0, 7), "nw_t0");
    cyc(mk(0, 0, 0, 5, 20'h2,   1, 0, 0, 0, 7), "nw_t1");
    cyc(mk(0, 0, 0, 5, 20'h10,  2, 1, 0, 0, 5), "nw_t2");
    cyc(mk(0, 0, 0, 5, 20'habc, 0, 0, 0, 0, 5), "nw_wrap");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
